prog_loader: RTL and testbench

Boot-time program loader for the Mini-MIPS core: accepts a byte stream on a valid/ready interface, assembles big-endian 32-bit words, and writes them to consecutive instruction-memory word addresses from 0. It holds the core in reset (`cpu_reset`) until the image is loaded, then releases it. It sits between the host/byte source and the `top` instruction memory write port, and drives the core's reset, which a bench otherwise drives directly.

---
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian words in instruction memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned Cap = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StLenHi = 3'd0,
    StLenLo = 3'd1,
    StData  = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    StCheck = 3'd3,
`endif
    StRun   = 3'd4,
    StError = 3'd5
  } state_e;

  state_e                state;
  logic [15:0]           len;
  logic [1:0]            byte_cnt;
  logic [23:0]           shift;
  logic [ADDR_WIDTH:0]   word_idx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic accept;
  assign accept = in_valid && in_ready;

  always_comb begin
    in_ready = (state == StLenHi) || (state == StLenLo) || (state == StData);
`ifdef PROG_LOADER_CHECKSUM_EN
    if (state == StCheck) in_ready = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StLenHi;
      len          <= '0;
      byte_cnt     <= '0;
      shift        <= '0;
      word_idx     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (imem_we) words_loaded <= words_loaded + 1'b1;
      case (state)
        StLenHi: begin
          if (accept) begin
            len[15:8] <= in_data;
            state     <= StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            len[7:0] <= in_data;
            if ({len[15:8], in_data} == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= StCheck;
`else
              state <= StRun;
`endif
            end else if (32'({len[15:8], in_data}) > Cap) begin
              state <= StError;
            end else begin
              state <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Write is registered so the next byte can be taken while it lands.
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_WIDTH-1:0];
              imem_wdata <= {shift, in_data};
              word_idx   <= word_idx + 1'b1;
              if (32'(word_idx) + 32'd1 == 32'(len)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state <= StCheck;
`else
                state <= StRun;
`endif
              end
            end else begin
              shift <= {shift[15:0], in_data};
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) state <= (in_data == csum) ? StRun : StError;
        end
`endif
        StRun: begin
          cpu_reset <= 1'b0;
          done      <= 1'b1;
        end
        StError: begin
          error <= 1'b1;
        end
        default: state <= StError;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames with random payloads and gaps.
module tb_prog_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int rel_cyc = -1;
  logic prev_we = 1'b0;
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write/release monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
      last_we_cyc = cyc;
      check("we_single_cycle", {63'd0, prev_we}, 64'd0);
    end
    if (!cpu_reset && rel_cyc < 0) rel_cyc = cyc;
    prev_we = imem_we;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset(input bit check_state);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    obs_addr.delete();
    obs_data.delete();
    rel_cyc = -1;
    last_we_cyc = -1;
    if (check_state) begin
      check("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_imem_we", {63'd0, imem_we}, 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'd0);
      check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_error", {63'd0, error}, 64'd0);
      check("rst_words_loaded", 64'(words_loaded), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Entered and left just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int wait_cnt;
    wait_cnt = 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && wait_cnt < 20) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    if (!in_ready) begin
      check("byte_accept_timeout", {63'd0, in_ready}, 64'd1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] words[$], input int len,
                          input int max_gap, input bit bad_csum);
    logic [7:0]  bytes[$];
    logic [7:0]  csum;
    logic [15:0] l;
    logic [31:0] w;
    bit          exp_err;
    int          exp_n;
    l = len[15:0];
    csum = 8'h00;
    bytes.push_back(l[15:8]);
    bytes.push_back(l[7:0]);
    exp_err = (len > (1 << AW));
    if (!exp_err) begin
      for (int k = 0; k < len; k++) begin
        w = words[k];
        for (int s = 3; s >= 0; s--) begin
          bytes.push_back(w[8*s +: 8]);
          csum ^= w[8*s +: 8];
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      bytes.push_back(csum ^ {7'd0, bad_csum});
      if (bad_csum) exp_err = 1'b1;
`endif
    end
    exp_n = (len > (1 << AW)) ? 0 : len;
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap));
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_nwrites"}, 64'(obs_addr.size()), 64'(exp_n));
    for (int k = 0; k < exp_n && k < obs_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), 64'(obs_addr[k]), 64'(k));
      check($sformatf("%s_data%0d", tag, k), 64'(obs_data[k]), 64'(words[k]));
    end
    check({tag, "_done"}, {63'd0, done}, {63'd0, !exp_err});
    check({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
    check({tag, "_cpu_reset"}, {63'd0, cpu_reset}, {63'd0, exp_err});
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_n));
`ifndef PROG_LOADER_CHECKSUM_EN
    if (!exp_err && exp_n > 0)
      check({tag, "_release_cycle"}, 64'(rel_cyc), 64'(last_we_cyc + 1));
`endif
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [7:0]  b;

    do_reset(1'b1);

    // Reference program from the core bring-up.
    wq = {32'h20080005, 32'h20090007, 32'h01095020};
    run_load("n3", wq, 3, 0, 1'b0);

    do_reset(1'b0);
    wq.delete();
    run_load("n0", wq, 0, 0, 1'b0);

    do_reset(1'b0);
    run_load("n257", wq, 257, 0, 1'b0);
    check("n257_never_we", 64'(last_we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

    do_reset(1'b0);
    wq = {$urandom(), $urandom()};
    run_load("n2_nogap", wq, 2, 0, 1'b0);
    do_reset(1'b0);
    run_load("n2_gap", wq, 2, 5, 1'b0);

    // Reset in the middle of a 4-word load, then a fresh single-word frame.
    do_reset(1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom());
      send_byte(b, $urandom_range(0, 2));
    end
    do_reset(1'b0);
    check("midrst_words_loaded", 64'(words_loaded), 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    wq = {$urandom()};
    run_load("midrst_n1", wq, 1, 1, 1'b0);

    // Full capacity: last write at the top address, no counter wrap.
    do_reset(1'b0);
    wq.delete();
    for (int i = 0; i < (1 << AW); i++) wq.push_back($urandom());
    run_load("full", wq, 1 << AW, 0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset(1'b0);
    wq = {32'h12345678};
    run_load("bad_csum", wq, 1, 0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
